// File: rtl/onchip_mem_arb_pkg.sv
// Shared widths, master ids and the request bundle used by the on-chip RAM arbiter.
package onchip_mem_arb_pkg;

  localparam int ADDR_W = 17;
  localparam int DATA_W = 32;
  localparam int BE_W   = DATA_W / 8;

  typedef enum logic {
    M0 = 1'b0,
    M1 = 1'b1
  } master_id_t;

  typedef struct packed {
    logic [ADDR_W-1:0] address;
    logic [BE_W-1:0]   byteenable;
    logic              read;
    logic              write;
    logic [DATA_W-1:0] writedata;
  } mem_req_t;

endpackage

// File: rtl/onchip_mem_rr_arbiter_rr_arb2.sv
// Two-way round-robin grant; the master that was not granted last wins a contention.
module rr_arb2
  import onchip_mem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  output logic [1:0] grant
);

  master_id_t last_grant;

  always_comb begin
    grant = 2'b00;
    if (!reset) begin
      if (req[0] && req[1]) grant = (last_grant == M0) ? 2'b10 : 2'b01;
      else                  grant = req;
    end
  end

  // Holds when idle so the next contention still favours the other master.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         last_grant <= M1;
    else if (grant[1]) last_grant <= M1;
    else if (grant[0]) last_grant <= M0;
  end

endmodule

// File: rtl/onchip_mem_rr_arbiter.sv
// Shares one single-port RAM between two Avalon-MM masters with round-robin grant
// and fixed one-cycle read latency routed back to the issuing master.
module onchip_mem_rr_arbiter #(
  parameter int ADDR_W = 17,
  parameter int DATA_W = 32,
  parameter int BE_W   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic [BE_W-1:0]   m0_byteenable,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic [BE_W-1:0]   m1_byteenable,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,
  output logic [ADDR_W-1:0] mem_address,
  output logic [BE_W-1:0]   mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  input  logic [DATA_W-1:0] mem_readdata,
  output logic              protocol_err
);

  import onchip_mem_arb_pkg::*;

  mem_req_t   req0_s, req1_s, sel_s;
  logic [1:0] req, grant;
  logic       rd_acc;
  logic       rd_pend_p1;
  master_id_t rd_id_p1;

  assign req0_s = '{address: m0_address, byteenable: m0_byteenable, read: m0_read,
                    write: m0_write, writedata: m0_writedata};
  assign req1_s = '{address: m1_address, byteenable: m1_byteenable, read: m1_read,
                    write: m1_write, writedata: m1_writedata};
  assign req    = {m1_read | m1_write, m0_read | m0_write};

  rr_arb2 u_arb (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .grant (grant)
  );

  assign m0_waitrequest = req[0] & ~grant[0];
  assign m1_waitrequest = req[1] & ~grant[1];

  // With no grant the m0 fields sit on the bus, harmless while chipselect is low.
  assign sel_s          = grant[1] ? req1_s : req0_s;
  assign mem_address    = sel_s.address;
  assign mem_byteenable = sel_s.byteenable;
  assign mem_writedata  = sel_s.writedata;
  assign mem_chipselect = |grant;
  assign mem_write      = (|grant) & sel_s.write;

  // Read together with write is executed as a write, so it never returns data.
  assign rd_acc = (|grant) & sel_s.read & ~sel_s.write;

  // Stage p0 -> p1: remember who issued the read whose data arrives next cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_pend_p1   <= 1'b0;
      protocol_err <= 1'b0;
    end else begin
      rd_pend_p1   <= rd_acc;
      protocol_err <= protocol_err | (m0_read & m0_write) | (m1_read & m1_write);
    end
  end

  always_ff @(posedge clk) begin
    if (rd_acc) rd_id_p1 <= grant[1] ? M1 : M0;
  end

  assign m0_readdatavalid = rd_pend_p1 & (rd_id_p1 == M0);
  assign m1_readdatavalid = rd_pend_p1 & (rd_id_p1 == M1);
  assign m0_readdata      = mem_readdata;
  assign m1_readdata      = mem_readdata;

endmodule

// File: tb/tb_onchip_mem_rr_arbiter.sv
// Randomised and directed scoreboard bench for the two-master on-chip RAM arbiter.
module tb_onchip_mem_rr_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [16:0] addr [2];
  logic [3:0]  be   [2];
  logic        rd   [2];
  logic        wr   [2];
  logic [31:0] wd   [2];
  logic        wait_o [2];
  logic [31:0] rdata  [2];
  logic        rdv    [2];
  logic [16:0] mem_address;
  logic [3:0]  mem_byteenable;
  logic        mem_chipselect, mem_write, protocol_err;
  logic [31:0] mem_writedata, mem_readdata;

  always #5 clk = ~clk;

  onchip_mem_rr_arbiter dut (
    .clk(clk), .reset(reset),
    .m0_address(addr[0]), .m0_byteenable(be[0]), .m0_read(rd[0]), .m0_write(wr[0]),
    .m0_writedata(wd[0]), .m0_waitrequest(wait_o[0]), .m0_readdata(rdata[0]),
    .m0_readdatavalid(rdv[0]),
    .m1_address(addr[1]), .m1_byteenable(be[1]), .m1_read(rd[1]), .m1_write(wr[1]),
    .m1_writedata(wd[1]), .m1_waitrequest(wait_o[1]), .m1_readdata(rdata[1]),
    .m1_readdatavalid(rdv[1]),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable),
    .mem_chipselect(mem_chipselect), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_readdata(mem_readdata),
    .protocol_err(protocol_err)
  );

  // Single-port RAM with unregistered q: data for the address clocked at edge N appears after it.
  logic [31:0] ram [0:102399];
  always @(posedge clk) begin
    if (mem_chipselect) begin
      if (mem_write)
        for (int b = 0; b < 4; b++)
          if (mem_byteenable[b]) ram[mem_address][b*8 +: 8] <= mem_writedata[b*8 +: 8];
      mem_readdata <= ram[mem_address];
    end
  end

  // Reference model: word memory, last winner, sticky error flag, per-master expected reads.
  logic [31:0] ref_mem [int];
  int          model_last;
  bit          perr_model;
  logic [31:0] exp_q0 [$];
  logic [31:0] exp_q1 [$];
  bit          acc [2];
  int          pass_cnt = 0;
  int          total_cnt = 0;
  logic [16:0] pool [8];

  task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  function automatic int qsize(int m);
    return (m == 0) ? exp_q0.size() : exp_q1.size();
  endfunction

  function automatic logic [31:0] qpop(int m);
    return (m == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
  endfunction

  function automatic logic [31:0] ref_rd(logic [16:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : 32'hxxxxxxxx;
  endfunction

  task automatic req_set(int m, bit r, bit w, logic [16:0] a, logic [3:0] b, logic [31:0] d);
    rd[m] = r; wr[m] = w; addr[m] = a; be[m] = b; wd[m] = d;
  endtask

  task automatic idle(int m);
    rd[m] = 1'b0; wr[m] = 1'b0;
  endtask

  // One bus cycle: predict grant from the round-robin rule, compare, update model.
  task automatic step();
    bit r [2];
    int g;
    logic [31:0] tmp;
    @(negedge clk);
    r[0] = rd[0] | wr[0];
    r[1] = rd[1] | wr[1];
    g = -1;
    if (!reset) begin
      if (r[0] && r[1]) g = (model_last == 0) ? 1 : 0;
      else if (r[0])    g = 0;
      else if (r[1])    g = 1;
    end
    check("m0_waitrequest", wait_o[0], r[0] && (g != 0));
    check("m1_waitrequest", wait_o[1], r[1] && (g != 1));
    check("protocol_err", protocol_err, perr_model);
    acc[0] = 1'b0;
    acc[1] = 1'b0;
    if (!reset)
      for (int m = 0; m < 2; m++) if (rd[m] && wr[m]) perr_model = 1'b1;
    if (g >= 0) begin
      acc[g] = 1'b1;
      model_last = g;
      if (wr[g]) begin
        tmp = ref_rd(addr[g]);
        for (int b = 0; b < 4; b++) if (be[g][b]) tmp[b*8 +: 8] = wd[g][b*8 +: 8];
        ref_mem[int'(addr[g])] = tmp;
      end else if (g == 0) exp_q0.push_back(ref_rd(addr[0]));
      else                 exp_q1.push_back(ref_rd(addr[1]));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_until_acc(int m);
    int n = 0;
    do begin
      step();
      n++;
    end while (!acc[m] && n < 16);
    if (!acc[m]) check("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic drain();
    idle(0);
    idle(1);
    step();
    step();
    check("m0_pending_reads", qsize(0), 0);
    check("m1_pending_reads", qsize(1), 0);
  endtask

  // Monitor: every readdatavalid pulse must match the oldest expected read of that master.
  always @(negedge clk) begin
    if (reset) begin
      check("m0_readdatavalid_in_reset", rdv[0], 1'b0);
      check("m1_readdatavalid_in_reset", rdv[1], 1'b0);
    end else begin
      for (int m = 0; m < 2; m++) begin
        if (rdv[m]) begin
          if (qsize(m) == 0) check(m == 0 ? "m0_unexpected_rdv" : "m1_unexpected_rdv", 64'd1, 64'd0);
          else check(m == 0 ? "m0_readdata" : "m1_readdata", rdata[m], qpop(m));
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    model_last = 1;
    perr_model = 1'b0;
    for (int m = 0; m < 2; m++) req_set(m, 1'b0, 1'b0, 17'h0, 4'h0, 32'h0);
    for (int i = 0; i < 8; i++) pool[i] = 17'h00100 + 17'(i * 7);

    @(negedge clk);
    check("reset_chipselect", mem_chipselect, 1'b0);
    check("reset_mem_write", mem_write, 1'b0);
    check("reset_protocol_err", protocol_err, 1'b0);
    check("reset_m0_waitrequest", wait_o[0], 1'b0);
    @(posedge clk);
    #1 reset = 1'b0;

    // Write then read back through m0.
    req_set(0, 1'b0, 1'b1, 17'h00010, 4'hF, 32'hDEADBEEF);
    run_until_acc(0);
    req_set(0, 1'b1, 1'b0, 17'h00010, 4'hF, 32'h0);
    run_until_acc(0);
    drain();

    // Seed the address pool from both masters.
    for (int i = 0; i < 8; i++) begin
      req_set(i % 2, 1'b0, 1'b1, pool[i], 4'hF, 32'hA5000000 + 32'(i));
      run_until_acc(i % 2);
      idle(i % 2);
    end

    // Both masters read continuously: grants must alternate, four returns each.
    for (int m = 0; m < 2; m++) req_set(m, 1'b1, 1'b0, pool[m * 7], 4'hF, 32'h0);
    for (int k = 0; k < 8; k++) begin
      step();
      for (int m = 0; m < 2; m++)
        if (acc[m]) addr[m] = pool[(m == 0) ? (k / 2 + 1) % 8 : 7 - (k / 2 + 1) % 8];
    end
    drain();

    // Partial byteenable into the top word.
    req_set(1, 1'b0, 1'b1, 17'h18FFF, 4'hF, 32'hFFFFFFFF);
    run_until_acc(1);
    req_set(1, 1'b0, 1'b1, 17'h18FFF, 4'b0011, 32'h12345678);
    run_until_acc(1);
    req_set(1, 1'b1, 1'b0, 17'h18FFF, 4'hF, 32'h0);
    run_until_acc(1);
    drain();

    // m0 reads, m1 overwrites the same word next cycle, m0 reads again.
    req_set(0, 1'b1, 1'b0, pool[3], 4'hF, 32'h0);
    run_until_acc(0);
    idle(0);
    req_set(1, 1'b0, 1'b1, pool[3], 4'hF, 32'hC0FFEE11);
    run_until_acc(1);
    idle(1);
    req_set(0, 1'b1, 1'b0, pool[3], 4'hF, 32'h0);
    run_until_acc(0);
    drain();

    // Read and write together from m1: executed as a write, error flag sticks.
    req_set(1, 1'b1, 1'b1, pool[5], 4'hF, 32'h5A5A0F0F);
    run_until_acc(1);
    idle(1);
    req_set(0, 1'b1, 1'b0, pool[5], 4'hF, 32'h0);
    run_until_acc(0);
    drain();

    // Randomised traffic over the pool; requests held until accepted.
    for (int k = 0; k < 400; k++) begin
      for (int m = 0; m < 2; m++) begin
        if (acc[m] || !(rd[m] | wr[m])) begin
          case ($urandom_range(0, 4))
            0, 1:    idle(m);
            2, 3:    req_set(m, 1'b1, 1'b0, pool[$urandom_range(0, 7)], 4'hF, 32'h0);
            default: req_set(m, 1'b0, 1'b1, pool[$urandom_range(0, 7)],
                             4'($urandom_range(1, 15)), $urandom);
          endcase
        end
      end
      step();
    end
    drain();

    // Reset lands in the data cycle of an accepted m0 read.
    req_set(0, 1'b1, 1'b0, pool[1], 4'hF, 32'h0);
    run_until_acc(0);
    reset = 1'b1;
    exp_q0.delete();
    exp_q1.delete();
    model_last = 1;
    perr_model = 1'b0;
    step();
    step();
    reset = 1'b0;
    req_set(1, 1'b1, 1'b0, pool[2], 4'hF, 32'h0);
    step();
    check("m0_first_after_reset", acc[0], 1'b1);
    drain();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
